// File: rtl/tof_i2c_cmd_sequencer.sv
// Command sequencer for the ToF I2C master: runs a table of single-byte register transactions.
// Define TOF_SEQ_RETRY_EN to retry a failing entry up to MAX_RETRY times before faulting.
module tof_i2c_cmd_sequencer #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned IDX_W      = 4,
  parameter logic [6:0]  SLAVE_ADDR = 7'h29,
  parameter int unsigned TIMEOUT    = 20000,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_wr_en,
  input  logic [IDX_W-1:0] cmd_wr_idx,
  input  logic [24:0]      cmd_wr_data,
  input  logic [IDX_W:0]   cmd_count,
  input  logic             go,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [IDX_W-1:0] fault_idx,
  output logic             rd_valid,
  output logic [7:0]       rd_data,
  output logic [IDX_W-1:0] rd_idx,
  output logic [6:0]       i2c_slave_addr,
  output logic [15:0]      i2c_reg_addr,
  output logic [7:0]       i2c_data_in,
  output logic             i2c_is_read,
  output logic [9:0]       i2c_nb_of_bytes,
  output logic             i2c_start,
  input  logic             i2c_ready,
  input  logic             i2c_error,
  input  logic [15:0]      i2c_data_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_CHECK, S_DONE, S_FAIL
  } state_e;

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
`ifdef TOF_SEQ_RETRY_EN
  localparam logic [RTY_W-1:0] RETRY_LIMIT = RTY_W'(MAX_RETRY);
`else
  localparam logic [RTY_W-1:0] RETRY_LIMIT = '0;
`endif

  logic [24:0]      table_q [DEPTH];
  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W:0]   count_q, count_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic [24:0]      entry_q, entry_d;
  logic             done_q, done_d, fault_q, fault_d, rd_valid_q, rd_valid_d;
  logic [IDX_W-1:0] fault_idx_q, fault_idx_d, rd_idx_q, rd_idx_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             step_failed, last_entry, timed_out;
  logic             unused_data_hi;

  assign last_entry     = ({1'b0, idx_q} == count_q - 1'b1);
  assign timed_out      = (tmo_q == TMO_LAST);
  assign unused_data_hi = ^i2c_data_out[15:8];

  // NOTE: the table is plain storage with no reset so it maps onto RAM; contents survive reset.
  always_ff @(posedge clock) begin
    if (cmd_wr_en) table_q[cmd_wr_idx] <= cmd_wr_data;
  end

  // NOTE: every register updates with <= so all of them see the same pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      count_q     <= '0;
      tmo_q       <= '0;
      retry_q     <= '0;
      entry_q     <= '0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      fault_idx_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_idx_q    <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      count_q     <= count_d;
      tmo_q       <= tmo_d;
      retry_q     <= retry_d;
      entry_q     <= entry_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      fault_idx_q <= fault_idx_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      rd_idx_q    <= rd_idx_d;
    end
  end

  // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    count_d     = count_q;
    retry_d     = retry_q;
    step_failed = 1'b0;
    case (state_q)
      S_IDLE: if (go) begin
        idx_d   = '0;
        retry_d = '0;
        count_d = cmd_count;
        state_d = (cmd_count == '0) ? S_DONE : S_LOAD;
      end
      S_LOAD:  state_d = S_ISSUE;
      S_ISSUE: if (!i2c_ready) state_d = S_WAIT;
               else if (timed_out) step_failed = 1'b1;
      S_WAIT:  if (i2c_ready) state_d = S_CHECK;
               else if (timed_out) step_failed = 1'b1;
      S_CHECK: if (i2c_error) step_failed = 1'b1;
               else if (last_entry) state_d = S_DONE;
               else begin
                 idx_d   = idx_q + 1'b1;
                 retry_d = '0;
                 state_d = S_LOAD;
               end
      S_DONE, S_FAIL: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A failed attempt re-runs the same entry while retries remain (never, without retry support).
    if (step_failed) begin
      if (retry_q != RETRY_LIMIT) begin
        retry_d = retry_q + 1'b1;
        state_d = S_LOAD;
      end else begin
        state_d = S_FAIL;
      end
    end
    tmo_d = (state_d == state_q && (state_q == S_ISSUE || state_q == S_WAIT)) ? tmo_q + 1'b1 : '0;
  end

  always_comb begin
    entry_d     = entry_q;
    done_d      = (state_q == S_DONE);
    fault_d     = fault_q;
    fault_idx_d = fault_idx_q;
    rd_valid_d  = 1'b0;
    rd_data_d   = rd_data_q;
    rd_idx_d    = rd_idx_q;
    case (state_q)
      S_IDLE:  if (go) fault_d = 1'b0;
      S_LOAD:  entry_d = table_q[idx_q];
      S_CHECK: if (!i2c_error && entry_q[24]) begin
        rd_valid_d = 1'b1;
        rd_data_d  = i2c_data_out[7:0];
        rd_idx_d   = idx_q;
      end
      S_FAIL: begin
        fault_d     = 1'b1;
        fault_idx_d = idx_q;
      end
      default: ;
    endcase
  end

  assign busy            = (state_q == S_LOAD) || (state_q == S_ISSUE) ||
                           (state_q == S_WAIT) || (state_q == S_CHECK);
  assign i2c_start       = (state_q == S_ISSUE);
  assign done            = done_q;
  assign fault           = fault_q;
  assign fault_idx       = fault_idx_q;
  assign rd_valid        = rd_valid_q;
  assign rd_data         = rd_data_q;
  assign rd_idx          = rd_idx_q;
  assign i2c_slave_addr  = SLAVE_ADDR;
  assign i2c_is_read     = entry_q[24];
  assign i2c_reg_addr    = entry_q[23:8];
  assign i2c_data_in     = entry_q[7:0];
  assign i2c_nb_of_bytes = 10'd1;

endmodule

// File: tb/tb_tof_i2c_cmd_sequencer.sv
// Directed bench for tof_i2c_cmd_sequencer with a small behavioural I2C engine model.
// Expectations follow TOF_SEQ_RETRY_EN when it is defined for the build.
module tb_tof_i2c_cmd_sequencer;
  localparam int TIMEOUT   = 40;
  localparam int MAX_RETRY = 3;
`ifdef TOF_SEQ_RETRY_EN
  localparam int ATTEMPTS = MAX_RETRY + 1;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic        clock = 1'b0, reset = 1'b1;
  logic        cmd_wr_en = 1'b0;
  logic [3:0]  cmd_wr_idx = '0;
  logic [24:0] cmd_wr_data = '0;
  logic [4:0]  cmd_count = '0;
  logic        go = 1'b0;
  logic        busy, done, fault, rd_valid, i2c_is_read, i2c_start;
  logic [3:0]  fault_idx, rd_idx;
  logic [7:0]  rd_data, i2c_data_in;
  logic [6:0]  i2c_slave_addr;
  logic [15:0] i2c_reg_addr;
  logic [9:0]  i2c_nb_of_bytes;
  logic        i2c_ready = 1'b1, i2c_error = 1'b0;
  logic [15:0] i2c_data_out = '0;

  tof_i2c_cmd_sequencer #(.DEPTH(16), .IDX_W(4), .SLAVE_ADDR(7'h29),
                          .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
    .clock(clock), .reset(reset), .cmd_wr_en(cmd_wr_en), .cmd_wr_idx(cmd_wr_idx),
    .cmd_wr_data(cmd_wr_data), .cmd_count(cmd_count), .go(go), .busy(busy), .done(done),
    .fault(fault), .fault_idx(fault_idx), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_idx(rd_idx), .i2c_slave_addr(i2c_slave_addr), .i2c_reg_addr(i2c_reg_addr),
    .i2c_data_in(i2c_data_in), .i2c_is_read(i2c_is_read), .i2c_nb_of_bytes(i2c_nb_of_bytes),
    .i2c_start(i2c_start), .i2c_ready(i2c_ready), .i2c_error(i2c_error),
    .i2c_data_out(i2c_data_out));

  always #5 clock = ~clock;

  // Engine model: accepts a start by dropping ready, completes model_lat negedges later.
  bit          model_accept = 1'b1;
  int          model_lat = 2;
  logic [15:0] model_rdata = '0;
  int          err_start = -1;
  int          start_cnt = 0;
  logic [15:0] log_addr [64];
  int          m_left = 0;
  bit          m_busy = 1'b0, m_bad = 1'b0;

  always @(negedge clock) begin
    if (!model_accept) begin
      i2c_ready = 1'b1;
      m_busy    = 1'b0;
    end else if (!m_busy) begin
      if (i2c_start) begin
        log_addr[start_cnt & 63] = i2c_reg_addr;
        m_bad     = (start_cnt == err_start);
        start_cnt = start_cnt + 1;
        i2c_ready = 1'b0;
        i2c_error = 1'b0;
        m_left    = model_lat;
        m_busy    = 1'b1;
      end
    end else begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        i2c_ready    = 1'b1;
        i2c_error    = m_bad;
        i2c_data_out = model_rdata;
        m_busy       = 1'b0;
      end
    end
  end

  int         done_cnt = 0, rd_cnt = 0, hi_cnt = 0;
  logic [7:0] last_rd_data = '0;
  logic [3:0] last_rd_idx = '0;

  always @(negedge clock) begin
    if (done) done_cnt = done_cnt + 1;
    if (i2c_start) hi_cnt = hi_cnt + 1;
    if (rd_valid) begin
      rd_cnt       = rd_cnt + 1;
      last_rd_data = rd_data;
      last_rd_idx  = rd_idx;
    end
  end

  int n_tests = 0, n_fail = 0;
  int r_cycles, r_starts, r_done, r_rd, r_hi, s0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic write_entry(input logic [3:0] idx, input logic [24:0] data);
    @(negedge clock);
    cmd_wr_en = 1'b1; cmd_wr_idx = idx; cmd_wr_data = data;
    @(negedge clock);
    cmd_wr_en = 1'b0;
  endtask

  // Pulses go and waits (bounded) for done or fault; r_* hold the deltas for this run.
  task automatic run_seq(input logic [4:0] cnt, input int budget);
    int d0, r0, h0;
    bit fin;
    s0 = start_cnt; d0 = done_cnt; r0 = rd_cnt; h0 = hi_cnt;
    fin = 1'b0; r_cycles = 0;
    @(negedge clock);
    cmd_count = cnt; go = 1'b1;
    for (int i = 0; i < budget && !fin; i++) begin
      @(negedge clock); #1;
      go = 1'b0;
      r_cycles++;
      if (done_cnt != d0 || fault) fin = 1'b1;
    end
    check("run_terminates", 32'(fin), 32'd1);
    repeat (2) @(negedge clock);
    #1;
    r_starts = start_cnt - s0; r_done = done_cnt - d0; r_rd = rd_cnt - r0; r_hi = hi_cnt - h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    repeat (3) @(negedge clock);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_fault", 32'(fault), 0);
    check("rst_start", 32'(i2c_start), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_reg_addr", 32'(i2c_reg_addr), 0);
    check("slave_addr", 32'(i2c_slave_addr), 32'h29);
    check("nb_of_bytes", 32'(i2c_nb_of_bytes), 1);
    reset = 1'b0;

    // T1: two writes, acknowledged by the engine
    write_entry(4'd0, {1'b0, 16'h7FFF, 8'h00});
    write_entry(4'd1, {1'b0, 16'h000B, 8'h01});
    run_seq(5'd2, 200);
    check("t1_starts", 32'(r_starts), 2);
    check("t1_addr0", 32'(log_addr[s0 & 63]), 32'h7FFF);
    check("t1_addr1", 32'(log_addr[(s0 + 1) & 63]), 32'h000B);
    check("t1_done", 32'(r_done), 1);
    check("t1_fault", 32'(fault), 0);
    check("t1_no_reads", 32'(r_rd), 0);
    check("t1_cycles", 32'(r_cycles), 12);
    check("t1_data_in", 32'(i2c_data_in), 32'h01);

    // T2: single read returning 0x00F0
    model_rdata = 16'h00F0;
    write_entry(4'd0, {1'b1, 16'h0000, 8'h00});
    run_seq(5'd1, 200);
    check("t2_rd_count", 32'(r_rd), 1);
    check("t2_rd_data", 32'(last_rd_data), 32'hF0);
    check("t2_rd_idx", 32'(last_rd_idx), 0);
    check("t2_rd_data_hold", 32'(rd_data), 32'hF0);
    check("t2_done", 32'(r_done), 1);
    check("t2_cycles", 32'(r_cycles), 7);

    // T3: engine never accepts -> timeout fault
    model_accept = 1'b0;
    run_seq(5'd1, 400);
    check("t3_fault", 32'(fault), 1);
    check("t3_fault_idx", 32'(fault_idx), 0);
    check("t3_no_done", 32'(r_done), 0);
    check("t3_start_low", 32'(i2c_start), 0);
    check("t3_busy_low", 32'(busy), 0);
    check("t3_start_cycles", 32'(r_hi), 32'(ATTEMPTS * TIMEOUT));
    check("t3_cycles", 32'(r_cycles), 32'(ATTEMPTS * (TIMEOUT + 1) + 2));
    model_accept = 1'b1;

    // T5: empty sequence
    run_seq(5'd0, 20);
    check("t5_cycles", 32'(r_cycles), 2);
    check("t5_starts", 32'(r_hi), 0);
    check("t5_done", 32'(r_done), 1);
    check("t5_fault_cleared", 32'(fault), 0);

    // T4: engine error on entry 2 of 4
    for (int i = 0; i < 4; i++) write_entry(4'(i), {1'b0, 16'h0100 + 16'(i), 8'h00});
    err_start = start_cnt + 2;
    run_seq(5'd4, 400);
    err_start = -1;
`ifdef TOF_SEQ_RETRY_EN
    check("t4_starts", 32'(r_starts), 5);
    check("t4_done", 32'(r_done), 1);
    check("t4_fault", 32'(fault), 0);
    check("t4_retry_addr", 32'(log_addr[(s0 + 3) & 63]), 32'h0102);
    check("t4_last_addr", 32'(log_addr[(s0 + 4) & 63]), 32'h0103);
`else
    check("t4_starts", 32'(r_starts), 3);
    check("t4_fault", 32'(fault), 1);
    check("t4_fault_idx", 32'(fault_idx), 2);
    check("t4_no_done", 32'(r_done), 0);
`endif

    // T6: reset while waiting for the engine
    write_entry(4'd0, {1'b0, 16'h0A00, 8'h5A});
    write_entry(4'd1, {1'b0, 16'h0A01, 8'h00});
    model_lat = 10;
    @(negedge clock);
    cmd_count = 5'd2; go = 1'b1;
    @(negedge clock);
    go = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock); #1;
      if (!i2c_ready) seen = 1'b1;
    end
    check("t6_engine_accepted", 32'(seen), 1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock); #1;
    check("t6_busy", 32'(busy), 0);
    check("t6_start", 32'(i2c_start), 0);
    check("t6_reg_addr", 32'(i2c_reg_addr), 0);
    check("t6_data_in", 32'(i2c_data_in), 0);
    check("t6_rd_data", 32'(rd_data), 0);
    check("t6_fault", 32'(fault), 0);
    check("t6_fault_idx", 32'(fault_idx), 0);
    reset = 1'b0;
    repeat (15) @(negedge clock);
    model_lat = 2;
    run_seq(5'd1, 200);
    check("t6_restart_starts", 32'(r_starts), 1);
    check("t6_restart_addr", 32'(log_addr[s0 & 63]), 32'h0A00);
    check("t6_restart_done", 32'(r_done), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
